mul_pipe: RTL and testbench



---
 rtl/mul_div_pkg.sv | 39 +++
 rtl/mul_stage.sv | 22 ++
 rtl/mul_pipe.sv | 163 ++++++++++++++++
 tb/tb_mul_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Types and helpers shared by the M-extension multiply/divide datapath.
package mul_div_pkg;

  localparam int XLEN      = 32;
  localparam int MAX_TAG_W = 16;

  typedef enum logic [1:0] {
    MODE_MUL    = 2'b00,
    MODE_MULH   = 2'b01,
    MODE_MULHSU = 2'b10,
    MODE_MULHU  = 2'b11
  } mode_t;

  // Tag is carried at its widest legal size; the top slices it back to TAG_W.
  typedef struct packed {
    logic [2*XLEN-1:0]    acc;
    logic [2*XLEN-1:0]    mcand;
    logic [XLEN-1:0]      mplier;
    logic                 neg;
    mode_t                mode;
    logic [MAX_TAG_W-1:0] tag;
    logic                 valid;
  } mul_stage_t;

  function automatic logic s_is_signed(input mode_t m);
    return (m == MODE_MULH) || (m == MODE_MULHSU);
  endfunction

  function automatic logic t_is_signed(input mode_t m);
    return (m == MODE_MULH);
  endfunction

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic            is_signed);
    return (is_signed && x[XLEN-1]) ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/mul_stage.sv
// One combinational shift-add step retiring STAGE_BITS multiplier bits.
module mul_stage
  import mul_div_pkg::*;
#(
  parameter int STAGE_BITS = 4
) (
  input  mul_stage_t stage_i,
  output mul_stage_t stage_o
);

  // Accumulate shifted multiplicand per set bit, then advance both operands.
  always_comb begin
    stage_o = stage_i;
    for (int i = 0; i < STAGE_BITS; i++) begin
      stage_o.acc = stage_o.acc +
                    (stage_i.mplier[i] ? (stage_i.mcand << i) : {(2*XLEN){1'b0}});
    end
    stage_o.mcand  = stage_i.mcand << STAGE_BITS;
    stage_o.mplier = stage_i.mplier >> STAGE_BITS;
  end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined 32x32 multiplier (MUL/MULH/MULHSU/MULHU), fixed NSTAGE-cycle latency.
// Optional feature: define MUL_PIPE_INFLIGHT_EN to add the inflight operation counter.
module mul_pipe
  import mul_div_pkg::*;
#(
  parameter  int STAGE_BITS = 4,
  parameter  int TAG_W      = 4,
  localparam int NSTAGE     = XLEN / STAGE_BITS
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic [XLEN-1:0]    s,
  input  logic [XLEN-1:0]    t,
  output logic               completed,
  output logic [TAG_W-1:0]   tag_out,
  output logic [2*XLEN-1:0]  product,
  output logic [XLEN-1:0]    result
`ifdef MUL_PIPE_INFLIGHT_EN
  ,
  output logic [$clog2(NSTAGE+1)-1:0] inflight
`endif
);

  mul_stage_t        issue;
  mul_stage_t        stage_out [NSTAGE];
  mul_stage_t        pipe_d    [NSTAGE-1];
  mul_stage_t        pipe_q    [NSTAGE-1];
  mul_stage_t        fin;
  logic              s_neg;
  logic              t_neg;
  logic [2*XLEN-1:0] signed_prod;

  logic              completed_d, completed_q;
  logic [TAG_W-1:0]  tag_out_d, tag_out_q;
  logic [2*XLEN-1:0] product_d, product_q;
  logic [XLEN-1:0]   result_d, result_q;

  // Convert the issued operands into the sign-magnitude payload of stage 1.
  always_comb begin
    issue        = '0;
    issue.mode   = mode_t'(mode);
    s_neg        = s_is_signed(issue.mode) & s[XLEN-1];
    t_neg        = t_is_signed(issue.mode) & t[XLEN-1];
    issue.acc    = {(2*XLEN){1'b0}};
    issue.mcand  = {{XLEN{1'b0}}, magnitude(s, s_is_signed(issue.mode))};
    issue.mplier = magnitude(t, t_is_signed(issue.mode));
    issue.neg    = s_neg ^ t_neg;
    issue.tag    = MAX_TAG_W'(tag_in);
    issue.valid  = enable;
  end

  // Stage 1 sees the issue payload; every later stage sees the register before it.
  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    mul_stage_t st_in;
    if (k == 0) begin : g_first
      assign st_in = issue;
    end else begin : g_rest
      assign st_in = pipe_q[k-1];
    end
    mul_stage #(
      .STAGE_BITS (STAGE_BITS)
    ) u_stage (
      .stage_i (st_in),
      .stage_o (stage_out[k])
    );
  end

  // Next-state of the inter-stage registers.
  always_comb begin
    for (int k = 0; k < NSTAGE - 1; k++) begin
      pipe_d[k] = stage_out[k];
    end
  end

  // Inter-stage registers; bubbles flow through with valid=0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NSTAGE - 1; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGE - 1; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  // Re-sign the final accumulator and hold outputs between completions.
  always_comb begin
    fin         = stage_out[NSTAGE-1];
    signed_prod = fin.neg ? (~fin.acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : fin.acc;
    completed_d = 1'b0;
    product_d   = product_q;
    result_d    = result_q;
    tag_out_d   = tag_out_q;
    if (fin.valid) begin
      completed_d = 1'b1;
      product_d   = signed_prod;
      result_d    = (fin.mode == MODE_MUL) ? signed_prod[XLEN-1:0]
                                           : signed_prod[2*XLEN-1:XLEN];
      tag_out_d   = fin.tag[TAG_W-1:0];
    end else begin
      completed_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      completed_q <= 1'b0;
      product_q   <= {(2*XLEN){1'b0}};
      result_q    <= {XLEN{1'b0}};
      tag_out_q   <= {TAG_W{1'b0}};
    end else begin
      completed_q <= completed_d;
      product_q   <= product_d;
      result_q    <= result_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign completed = completed_q;
  assign product   = product_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

  // The last stage's shifted operands and tag padding are dead by construction.
  logic unused_tail;
  assign unused_tail = ^{fin.mcand, fin.mplier, fin.tag};

`ifdef MUL_PIPE_INFLIGHT_EN
  localparam int CNT_W = $clog2(NSTAGE + 1);

  logic [CNT_W-1:0] inflight_d, inflight_q;

  // Count issues up and completions down; both together cancel.
  always_comb begin
    inflight_d = inflight_q;
    case ({enable, completed_q})
      2'b10:   inflight_d = (inflight_q == CNT_W'(NSTAGE)) ? inflight_q
                                                           : inflight_q + CNT_W'(1);
      2'b01:   inflight_d = (inflight_q == {CNT_W{1'b0}}) ? inflight_q
                                                          : inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // Inflight counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= {CNT_W{1'b0}};
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight = inflight_q;
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed table, back-to-back, mid-flight reset and random ops.
// With MUL_PIPE_INFLIGHT_EN defined the inflight counter is checked as well.
module tb_mul_pipe;

  localparam int STAGE_BITS = 4;
  localparam int TAG_W      = 4;
  localparam int NSTAGE     = 32 / STAGE_BITS;
  localparam int NVEC       = 10;

  logic             clk = 1'b0;
  logic             rstn;
  logic             enable;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag_in;
  logic [31:0]      s;
  logic [31:0]      t;
  logic             completed;
  logic [TAG_W-1:0] tag_out;
  logic [63:0]      product;
  logic [31:0]      result;
`ifdef MUL_PIPE_INFLIGHT_EN
  logic [$clog2(NSTAGE+1)-1:0] inflight;
  int               inflight_peak = 0;
`endif

  typedef struct {
    logic [63:0]      prod;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  typedef struct {
    logic [1:0]       m;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tg;
    logic [63:0]      ep;
    logic [31:0]      er;
  } vec_t;

  exp_t             sb[$];
  vec_t             vecs[NVEC];
  int               cyc      = 0;
  int               n_checks = 0;
  int               n_fail   = 0;
  int               n_done   = 0;
  logic [63:0]      last_prod;
  logic [31:0]      last_res;
  logic [TAG_W-1:0] last_tag;

  mul_pipe #(
    .STAGE_BITS (STAGE_BITS),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .mode      (mode),
    .tag_in    (tag_in),
    .s         (s),
    .t         (t),
    .completed (completed),
    .tag_out   (tag_out),
    .product   (product),
    .result    (result)
`ifdef MUL_PIPE_INFLIGHT_EN
    ,
    .inflight  (inflight)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: extend each operand per its signedness, multiply, keep 64 bits.
  function automatic logic [63:0] ref_prod(input logic [1:0] m, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tg, input logic [63:0] ep,
                       input logic [31:0] er, input bit track);
    exp_t e;
    enable = 1'b1;
    mode   = m;
    s      = a;
    t      = b;
    tag_in = tg;
    if (track) begin
      e.prod = ep;
      e.res  = er;
      e.tag  = tg;
      e.due  = cyc + NSTAGE;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < NSTAGE + 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    idle(2);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: in-order scoreboard, exact latency, and hold between completions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_prod = 64'd0;
        last_res  = 32'd0;
        last_tag  = {TAG_W{1'b0}};
      end else if (completed) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("spurious_completed", 64'(completed), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc), 64'(e.due));
          chk("product", product, e.prod);
          chk("result", 64'(result), 64'(e.res));
          chk("tag_out", 64'(tag_out), 64'(e.tag));
          last_prod = e.prod;
          last_res  = e.res;
          last_tag  = e.tag;
        end
      end else begin
        chk("hold_product", product, last_prod);
        chk("hold_result", 64'(result), 64'(last_res));
        chk("hold_tag", 64'(tag_out), 64'(last_tag));
      end
`ifdef MUL_PIPE_INFLIGHT_EN
      if (int'(inflight) > inflight_peak) inflight_peak = int'(inflight);
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]       m;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tg;
    logic [63:0]      p;
    int               d0;

    vecs[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFE};
    vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 4'd5, 64'h4000_0000_0000_0000, 32'h4000_0000};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0007, 4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFFF};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 64'hFFFF_FFFF_0000_0001, 32'hFFFF_FFFF};
    vecs[4] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 4'd8, 64'h0000_0006_FFFF_FFEB, 32'hFFFF_FFEB};
    vecs[5] = '{2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 4'd9, 64'h0000_0000_0000_0000, 32'h0000_0000};
    vecs[6] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd10, 64'h3FFF_FFFF_0000_0001, 32'h3FFF_FFFF};
    vecs[7] = '{2'b11, 32'h0000_0001, 32'hFFFF_FFFF, 4'd11, 64'h0000_0000_FFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 4'd12, 64'hC000_0000_8000_0000, 32'hC000_0000};
    vecs[9] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 64'h8000_0000_8000_0000, 32'h8000_0000};

    rstn   = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    tag_in = {TAG_W{1'b0}};
    s      = 32'd0;
    t      = 32'd0;
    #2 rstn = 1'b0;

    @(negedge clk);
    chk("reset_completed", 64'(completed), 64'd0);
    chk("reset_product", product, 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_tag_out", 64'(tag_out), 64'd0);
`ifdef MUL_PIPE_INFLIGHT_EN
    chk("reset_inflight", 64'(inflight), 64'd0);
`endif
    @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    // Directed table; the first entry runs in isolation.
    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].tg, vecs[i].ep, vecs[i].er, 1'b1);
      idle((i == 0) ? NSTAGE + 2 : 2);
    end
    drain();

    // Eight back-to-back issues must complete on consecutive cycles in order.
`ifdef MUL_PIPE_INFLIGHT_EN
    inflight_peak = 0;
`endif
    for (int i = 0; i < 8; i++) begin
      issue(2'b00, 32'(i), 32'(i + 1), TAG_W'(i), 64'(i * (i + 1)), 32'(i * (i + 1)), 1'b1);
    end
    drain();
`ifdef MUL_PIPE_INFLIGHT_EN
    chk("inflight_peak", 64'(inflight_peak), 64'(NSTAGE));
    chk("inflight_end", 64'(inflight), 64'd0);
`endif

    // Random operations with corner operands and bubbles.
    for (int n = 0; n < 10000; n++) begin
      m  = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      tg = TAG_W'($urandom);
      p  = ref_prod(m, a, b);
      issue(m, a, b, tg, p, (m == 2'b00) ? p[31:0] : p[63:32], 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Mid-flight reset discards everything in the pipe.
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 32'hFFFF_FFFF, 32'(i + 5), TAG_W'(i + 1), 64'd0, 32'd0, 1'b0);
    end
    idle(1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midreset_completed", 64'(completed), 64'd0);
    chk("midreset_product", product, 64'd0);
    chk("midreset_result", 64'(result), 64'd0);
    chk("midreset_tag_out", 64'(tag_out), 64'd0);
`ifdef MUL_PIPE_INFLIGHT_EN
    chk("midreset_inflight", 64'(inflight), 64'd0);
`endif
    @(posedge clk);
    #1 rstn = 1'b1;
    d0 = n_done;
    idle(16);
    chk("no_completed_after_reset", 64'(n_done - d0), 64'd0);

    // Pipe must work normally after the reset.
    issue(vecs[3].m, vecs[3].a, vecs[3].b, vecs[3].tg, vecs[3].ep, vecs[3].er, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
